// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter that loads one requester's word per cycle into a shared output register.
// The pointer rotates past each granted requester so that all requesters get fair service.
module reg_rr_arbiter #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic [W-1:0]         d_out,
    output logic                 d_out_valid,
    input  logic                 d_out_ready,
    output logic [$clog2(N)-1:0] d_out_src,
    output logic [15:0]          acc_cnt
);

    localparam int SW = $clog2(N);

    logic [W-1:0]  r_dout;
    logic [SW-1:0] r_src;
    logic          r_full;
    logic [SW-1:0] r_ptr;
    logic [15:0]   r_cnt;

    logic          w_can_load;
    logic          w_any;
    logic [SW-1:0] w_gnt;
    logic          w_accept;

    // Scan from the highest offset down so the closest requester after ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[r_ptr + SW'(k)]) begin
                w_any = 1'b1;
                w_gnt = r_ptr + SW'(k);
            end
        end
    end

    assign w_can_load = resetn && (!r_full || d_out_ready);
    assign w_accept   = w_can_load && w_any;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = w_accept && (w_gnt == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout <= '0;
            r_src  <= '0;
            r_full <= 1'b0;
            r_ptr  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_dout <= req_data[w_gnt*W +: W];
            r_src  <= w_gnt;
            r_full <= 1'b1;
            r_ptr  <= w_gnt + SW'(1);
            r_cnt  <= r_cnt + 16'd1;
        end else if (r_full && d_out_ready) begin
            r_full <= 1'b0;
        end
    end

    assign d_out       = r_dout;
    assign d_out_valid = r_full;
    assign d_out_src   = r_src;
    assign acc_cnt     = r_cnt;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Bench for reg_rr_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a queue-free behavioural model of the arbiter.
module tb_reg_rr_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [W-1:0]  d_out;
    logic          d_out_valid;
    logic          d_out_ready = 1'b0;
    logic [1:0]    d_out_src;
    logic [15:0]   acc_cnt;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model state
    int   m_dout = 0;
    int   m_src  = 0;
    bit   m_full = 1'b0;
    int   m_ptr  = 0;
    int   m_cnt  = 0;

    reg_rr_arbiter #(.W(W), .N(N)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .d_out      (d_out),
        .d_out_valid(d_out_valid),
        .d_out_ready(d_out_ready),
        .d_out_src  (d_out_src),
        .acc_cnt    (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // First requester at or after ptr (cyclically) that is requesting, or -1.
    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int exp_ready();
        int g;
        g = pick(m_ptr, req_valid);
        if (!resetn || (m_full && !d_out_ready) || g < 0) return 0;
        return 1 << g;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_dout <= 0;
            m_src  <= 0;
            m_full <= 1'b0;
            m_ptr  <= 0;
            m_cnt  <= 0;
        end else begin
            int g;
            g = pick(m_ptr, req_valid);
            if ((!m_full || d_out_ready) && g >= 0) begin
                m_dout <= int'(req_data[g*W +: W]);
                m_src  <= g;
                m_full <= 1'b1;
                m_ptr  <= (g + 1) % N;
                m_cnt  <= (m_cnt + 1) % 65536;
            end else if (m_full && d_out_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ready", int'(req_ready), exp_ready());
            chk("model_dout", int'(d_out), m_dout);
            chk("model_valid", int'(d_out_valid), int'(m_full));
            chk("model_src", int'(d_out_src), m_src);
            chk("model_cnt", int'(acc_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #1;
        resetn = 1'b0;
        chk_en = 1'b1;
        req_valid = 4'b1111;
        req_data = 32'h44332211;

        // Reset held for 7 cycles with all requests asserted
        for (int i = 0; i < 7; i++) begin
            tick();
            #2;
            chk("rst_ready", int'(req_ready), 0);
            chk("rst_valid", int'(d_out_valid), 0);
            chk("rst_dout", int'(d_out), 0);
        end
        resetn = 1'b1;
        req_valid = '0;
        tick();

        // Single word from requester 0
        req_valid = 4'b0001;
        req_data = 32'h000000A5;
        d_out_ready = 1'b1;
        #2;
        chk("first_ready", int'(req_ready), 1);
        tick();
        #2;
        chk("first_dout", int'(d_out), 8'hA5);
        chk("first_valid", int'(d_out_valid), 1);
        chk("first_src", int'(d_out_src), 0);
        chk("first_cnt", int'(acc_cnt), 1);

        // Full rotation from ptr=0
        req_valid = '0;
        sync_reset();
        req_valid = 4'b1111;
        req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rot_ready", int'(req_ready), 1 << (k % 4));
            tick();
            #2;
            chk("rot_src", int'(d_out_src), k % 4);
            chk("rot_dout", int'(d_out), ((k % 4) + 1) * 8'h11);
        end

        // Stalled word 3C, then release
        req_valid = 4'b0001;
        req_data = 32'h0000003C;
        #2;
        chk("load3c_ready", int'(req_ready), 1);
        tick();
        d_out_ready = 1'b0;
        req_valid = 4'b1111;
        req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("stall_ready", int'(req_ready), 0);
            chk("stall_dout", int'(d_out), 8'h3C);
            tick();
        end
        d_out_ready = 1'b1;
        #2;
        chk("release_ready", int'(req_ready), 4'b0010);
        tick();
        #2;
        chk("release_src", int'(d_out_src), 1);

        // ptr=1 with 1001: grant 3 then 0
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        repeat (2) tick();
        req_valid = 4'b1001;
        #2;
        chk("p1_ready3", int'(req_ready), 4'b1000);
        tick();
        #2;
        chk("p1_src3", int'(d_out_src), 3);
        chk("p1_ready0", int'(req_ready), 4'b0001);
        tick();
        #2;
        chk("p1_src0", int'(d_out_src), 0);
        // ptr=1 held through idle cycles
        req_valid = 4'b0000;
        repeat (3) tick();
        req_valid = 4'b0011;
        #2;
        chk("p1_hold_ready", int'(req_ready), 4'b0010);
        tick();

        // Asynchronous reset mid-cycle while full
        req_valid = 4'b0001;
        req_data = 32'h0000005A;
        tick();
        d_out_ready = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("pre_async_valid", int'(d_out_valid), 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_valid", int'(d_out_valid), 0);
        chk("async_dout", int'(d_out), 0);
        chk("async_src", int'(d_out_src), 0);
        #3;
        resetn = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data = $urandom;
            d_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                resetn = 1'b0;
                #4;
                resetn = 1'b1;
            end
            tick();
        end

        // Counter wrap after 65536 accepts
        req_valid = 4'b1111;
        d_out_ready = 1'b1;
        sync_reset();
        repeat (65535) tick();
        #2;
        chk("cnt_ffff", int'(acc_cnt), 16'hFFFF);
        tick();
        #2;
        chk("cnt_wrap", int'(acc_cnt), 0);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
